prince_inv_sbox_ti_serial: RTL and testbench
============================================

PRINCE_INV_SBOX_TI_SERIAL -- requirements
Module: prince_inv_sbox_ti_serial

Interface
REQ-001 The block SHALL have a parameter NIBBLES, default 16, giving the number of 4-bit nibbles per state word.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, with asynchronous active-low reset.
REQ-004 Ports in_s0, in_s1, in_s2, in_s3 SHALL be inputs, 64 bits each, the four Boolean shares of the ciphertext-side state.
REQ-005 Port in_valid SHALL be an input, 1 bit, and mark the input shares as valid.
REQ-006 Port in_ready SHALL be an output, 1 bit, and indicate that the block accepts a new state.
REQ-007 Port rnd SHALL be an input, 12 bits, carrying fresh guard randomness m0=rnd[3:0], m1=rnd[7:4] and m2=rnd[11:8].
REQ-008 Ports out_s0, out_s1, out_s2, out_s3 SHALL be outputs, 64 bits each, the four shares of the inverse-S-box-layer result.
REQ-009 Port out_valid SHALL be an output, 1 bit, and mark the output shares as valid.
REQ-010 Port out_ready SHALL be an input, 1 bit, indicating that the consumer accepts the output.

Function
REQ-011 The block SHALL compute the PRINCE inverse S-box S^-1 = {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1} on every nibble, on shared data, without ever combining all four shares.
REQ-012 Output share i SHALL be produced by a non-complete component function that omits input share i; this is a cubic first-order threshold implementation with 4 shares.
REQ-013 The component outputs SHALL be remasked using changing of the guards:
- Share 0 SHALL be XORed with m0.
- Share 1 SHALL be XORed with m0^m1.
- Share 2 SHALL be XORed with m1^m2.
- Share 3 SHALL be XORed with m2.
REQ-014 The XOR of the output shares SHALL equal S^-1 of the XOR of the input shares, per nibble.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; when in_valid=1 the block SHALL capture all four shares into a shift register, clear nibble counter cnt, and go to RUN.
REQ-017 In RUN, each cycle SHALL process nibble cnt, taken as bits [4cnt+3:4cnt] with nibble 0 first.
REQ-018 In RUN, the remasked component outputs SHALL be registered into the result shift register at the corresponding nibble, and rnd SHALL be sampled in that same cycle.
REQ-019 In RUN, cnt SHALL increment each cycle; when cnt=NIBBLES-1, the next state SHALL be DONE and cnt SHALL wrap to 0.
REQ-020 In DONE, out_valid SHALL be 1 and out_s0..out_s3 SHALL be stable.
REQ-021 In DONE, when out_ready=1 the next state SHALL be IDLE.
REQ-022 A DONE-to-IDLE transition and a new acceptance SHALL NOT occur in the same cycle; in_ready SHALL be 0 in DONE.
REQ-023 Latency from the acceptance cycle to the first out_valid=1 cycle SHALL be NIBBLES+1 cycles (17 at default).
REQ-024 Throughput SHALL be one state per NIBBLES+2 cycles when out_ready is held at 1.
REQ-025 The block SHALL ignore in_valid in RUN and DONE; input shares in those states SHALL have no effect.
REQ-026 Each nibble SHALL be processed with the register stage between the component functions and the share recombination wiring; no combinational path SHALL exist from in_s* to out_s*.
REQ-027 in_ready SHALL depend only on state, and out_valid SHALL depend only on state.

Reset
REQ-028 While rst_n=0, the block SHALL be in state IDLE with cnt=0, in_ready=1, out_valid=0, and all share registers at 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL discard the state at once, and no out_valid pulse SHALL follow.
REQ-030 After reset is released, the first rising edge SHALL behave as IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, NIBBLES_DEFAULT, the S^-1 table constant (for the bench model), and the rnd field offsets.
REQ-032 The block SHALL contain exactly one sub-module, inv_component_function, which is 4-bit and combinational, takes three input shares plus a 4-bit guard, and yields one output share.
REQ-033 The top level SHALL instantiate inv_component_function four times, with shares rotated accordingly.

Verification
REQ-034 Unshared input 0x0123456789ABCDEF (s1=s2=s3=random, s0 fixed so the shares XOR to that value), rnd random -> the XOR of the output shares SHALL be 0xB732FD89A6405EC1 and out_valid SHALL rise 17 cycles after acceptance.
REQ-035 Input shares all 0, rnd=0 -> every output share nibble SHALL satisfy XOR = 0xB, and each share SHALL be a deterministic function of rnd.
REQ-036 With out_ready held at 0 for 10 cycles in DONE -> outputs SHALL stay stable, in_ready SHALL stay 0, and in_valid pulses SHALL be ignored.
REQ-037 Two back-to-back states with out_ready=1 -> the second SHALL be accepted exactly NIBBLES+2 cycles after the first.
REQ-038 rst_n pulsed low at cnt=7 -> the block SHALL immediately show out_valid=0 and in_ready=1, and the next accepted state SHALL produce the correct result.
REQ-039 Over 10^4 random vectors, compare against the unmasked S^-1 model; separately, a probing check (PROLEAD, first order, glitch model) SHALL report no leakage.

Source files
------------

// File: rtl/prince_inv_sbox_ti_serial_pkg.sv
// Shared types, constants and the direct-sharing evaluator for the 4-share
// threshold implementation of the PRINCE inverse S-box.
package prince_inv_sbox_ti_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLES_DEFAULT = 16;
  localparam int unsigned SHARES          = 4;

  // Nibble i of the constant holds S^-1(i).
  localparam logic [63:0] INV_SBOX_TABLE = 64'h1CE5_046A_98DF_237B;

  localparam int unsigned RND_W      = 12;
  localparam int unsigned RND_M0_LSB = 0;
  localparam int unsigned RND_M1_LSB = 4;
  localparam int unsigned RND_M2_LSB = 8;

  // Algebraic normal form of one output bit (Moebius transform of the table).
  function automatic logic [15:0] anf_of_bit(input int unsigned b);
    logic [15:0] a;
    a = '0;
    for (int unsigned x = 0; x < 16; x++) a[4'(x)] = INV_SBOX_TABLE[6'(4 * x + b)];
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned x = 0; x < 16; x++)
        if (((x >> i) & 32'd1) != 0) a[4'(x)] = a[4'(x)] ^ a[4'(x ^ (32'd1 << i))];
    return a;
  endfunction

  localparam logic [63:0] INV_SBOX_ANF = {anf_of_bit(3), anf_of_bit(2), anf_of_bit(1), anf_of_bit(0)};

  // Sum of all share-expanded monomial terms owned by output share 'omit'.
  // A term is owned by the lowest share index it does not touch, so share
  // 'omit' never reads input share 'omit' (non-completeness).
  function automatic logic [3:0] component_eval(input logic [15:0] xs, input int unsigned omit);
    logic [3:0]  y;
    logic [3:0]  used;
    logic        prod;
    logic        ok;
    int unsigned idx;
    int unsigned owner;
    y = '0;
    for (int unsigned o = 0; o < 4; o++)
      for (int unsigned m = 0; m < 16; m++)
        if (INV_SBOX_ANF[6'(16 * o + m)])
          for (int unsigned t = 0; t < 256; t++) begin
            ok   = 1'b1;
            used = '0;
            prod = 1'b1;
            for (int unsigned v = 0; v < 4; v++) begin
              idx = (t >> (2 * v)) & 32'd3;
              if (((m >> v) & 32'd1) != 0) begin
                used[2'(idx)] = 1'b1;
                prod = prod & xs[4'(4 * idx + v)];
              end else if (idx != 0) begin
                ok = 1'b0;
              end
            end
            owner = 4;
            for (int unsigned k = 4; k > 0; k--)
              if (!used[2'(k - 1)]) owner = k - 1;
            if (ok && owner == omit) y[2'(o)] = y[2'(o)] ^ prod;
          end
    return y;
  endfunction

endpackage

// File: rtl/inv_component_function.sv
// One non-complete component of the shared inverse S-box plus its guard mask.
module inv_component_function
  import prince_inv_sbox_ti_serial_pkg::*;
#(
  parameter int unsigned OMIT = 0
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] guard,
  output logic [3:0] y_c
);

  localparam int unsigned IA = 4 * ((OMIT + 1) % 4);
  localparam int unsigned IB = 4 * ((OMIT + 2) % 4);
  localparam int unsigned IC = 4 * ((OMIT + 3) % 4);

  logic [15:0] xs;

  // Inputs arrive rotated: a, b, c are shares OMIT+1, OMIT+2, OMIT+3 (mod 4).
  always_comb begin
    xs         = '0;
    xs[IA +: 4] = a;
    xs[IB +: 4] = b;
    xs[IC +: 4] = c;
    y_c        = component_eval(xs, OMIT) ^ guard;
  end

endmodule

// File: rtl/prince_inv_sbox_ti_serial.sv
// Nibble-serial, 4-share threshold implementation of the PRINCE inverse S-box
// layer with changing-of-the-guards remasking.
module prince_inv_sbox_ti_serial
  import prince_inv_sbox_ti_serial_pkg::*;
#(
  parameter  int unsigned NIBBLES = NIBBLES_DEFAULT,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_s0,
  input  logic [W-1:0]     in_s1,
  input  logic [W-1:0]     in_s2,
  input  logic [W-1:0]     in_s3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RND_W-1:0] rnd,
  output logic [W-1:0]     out_s0,
  output logic [W-1:0]     out_s1,
  output logic [W-1:0]     out_s2,
  output logic [W-1:0]     out_s3,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  in_s  [SHARES];
  logic [W-1:0]  sh_q  [SHARES];
  logic [W-1:0]  res_q [SHARES];
  logic [3:0]    nib   [SHARES];
  logic [3:0]    guard [SHARES];
  logic [3:0]    y_c   [SHARES];
  logic [3:0]    m0, m1, m2;

  assign in_s[0] = in_s0;
  assign in_s[1] = in_s1;
  assign in_s[2] = in_s2;
  assign in_s[3] = in_s3;

  assign m0 = rnd[RND_M0_LSB +: 4];
  assign m1 = rnd[RND_M1_LSB +: 4];
  assign m2 = rnd[RND_M2_LSB +: 4];

  assign guard[0] = m0;
  assign guard[1] = m0 ^ m1;
  assign guard[2] = m1 ^ m2;
  assign guard[3] = m2;

  // The input shift register presents the current nibble at the bottom.
  always_comb begin
    for (int k = 0; k < SHARES; k++) nib[k] = sh_q[k][3:0];
  end

  for (genvar i = 0; i < SHARES; i++) begin : g_cf
    inv_component_function #(
      .OMIT(i)
    ) u_cf (
      .a    (nib[(i + 1) % SHARES]),
      .b    (nib[(i + 2) % SHARES]),
      .c    (nib[(i + 3) % SHARES]),
      .guard(guard[i]),
      .y_c  (y_c[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake flags; results shift in from the top so nibble 0
  // lands at the bottom after the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHARES; k++) begin
        sh_q[k]  <= '0;
        res_q[k] <= '0;
      end
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < SHARES; k++) sh_q[k] <= in_s[k];
            cnt_q <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < SHARES; k++) begin
            sh_q[k]  <= sh_q[k] >> 4;
            res_q[k] <= {y_c[k], res_q[k][W-1:4]};
          end
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_s0 = res_q[0];
  assign out_s1 = res_q[1];
  assign out_s2 = res_q[2];
  assign out_s3 = res_q[3];

endmodule

// File: tb/tb_prince_inv_sbox_ti_serial.sv
// Directed self-checking bench for the serial shared PRINCE inverse S-box layer.
module tb_prince_inv_sbox_ti_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_s0, in_s1, in_s2, in_s3;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] rnd;
  logic [63:0] out_s0, out_s1, out_s2, out_s3;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rnd = 1'b0;

  logic [3:0] sinv [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                            4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  always #5 clk = ~clk;

  prince_inv_sbox_ti_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_s0    (in_s0),
    .in_s1    (in_s1),
    .in_s2    (in_s2),
    .in_s3    (in_s3),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rnd      (rnd),
    .out_s0   (out_s0),
    .out_s1   (out_s1),
    .out_s2   (out_s2),
    .out_s3   (out_s3),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [63:0] model(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sinv[x[4*i +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] out_xor();
    return out_s0 ^ out_s1 ^ out_s2 ^ out_s3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rnd) rnd = 12'($urandom);
  endtask

  task automatic drive_plain(input logic [63:0] p);
    in_s1 = rand64();
    in_s2 = rand64();
    in_s3 = rand64();
    in_s0 = p ^ in_s1 ^ in_s2 ^ in_s3;
  endtask

  // Offers one state from IDLE and waits (bounded) for out_valid.
  task automatic run_vec(output int lat, output bit timeout);
    in_valid = 1'b1;
    lat      = 0;
    timeout  = 1'b0;
    tick();
    lat++;
    in_valid = 1'b0;
    drive_plain(rand64());
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic finish_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd = '0;
    in_s0 = '0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
    #23;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if ({out_s0, out_s1, out_s2, out_s3} !== 256'h0)
      $display("FAIL reset_shares: got %h %h %h %h expected all 0", out_s0, out_s1, out_s2, out_s3);
    else n_pass++;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_holds_idle: got in_ready %b expected 1", in_ready); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_vector();
    int lat; bit to;
    rand_rnd = 1'b1;
    drive_plain(64'h0123456789ABCDEF);
    run_vec(lat, to);
    n_checks++; if (to) $display("FAIL known_timeout: got no out_valid expected out_valid"); else n_pass++;
    n_checks++; if (lat != 17) $display("FAIL known_latency: got %0d expected 17", lat); else n_pass++;
    n_checks++;
    if (out_xor() !== 64'hB732FD89A6405EC1) $display("FAIL known_result: got %h expected B732FD89A6405EC1", out_xor());
    else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL known_done_in_ready: got %b expected 0", in_ready); else n_pass++;
    finish_done();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL known_back_idle: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_zero_input();
    int lat; bit to;
    logic [63:0] r0 [4];
    logic [63:0] g  [4];
    rand_rnd = 1'b0;
    g[0] = {16{4'h1}}; g[1] = {16{4'h3}}; g[2] = {16{4'h1}}; g[3] = {16{4'h3}};
    for (int pass = 0; pass < 2; pass++) begin
      rnd = (pass == 0) ? 12'h000 : 12'h321;
      in_s0 = '0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
      run_vec(lat, to);
      in_s0 = '0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
      n_checks++; if (to) $display("FAIL zero_timeout: pass %0d no out_valid", pass); else n_pass++;
      n_checks++;
      if (out_xor() !== {16{4'hB}}) $display("FAIL zero_result: pass %0d got %h expected %h", pass, out_xor(), {16{4'hB}});
      else n_pass++;
      if (pass == 0) begin
        r0[0] = out_s0; r0[1] = out_s1; r0[2] = out_s2; r0[3] = out_s3;
      end else begin
        n_checks++; if ((out_s0 ^ r0[0]) !== g[0]) $display("FAIL zero_guard0: got %h expected %h", out_s0 ^ r0[0], g[0]); else n_pass++;
        n_checks++; if ((out_s1 ^ r0[1]) !== g[1]) $display("FAIL zero_guard1: got %h expected %h", out_s1 ^ r0[1], g[1]); else n_pass++;
        n_checks++; if ((out_s2 ^ r0[2]) !== g[2]) $display("FAIL zero_guard2: got %h expected %h", out_s2 ^ r0[2], g[2]); else n_pass++;
        n_checks++; if ((out_s3 ^ r0[3]) !== g[3]) $display("FAIL zero_guard3: got %h expected %h", out_s3 ^ r0[3], g[3]); else n_pass++;
      end
      finish_done();
    end
  endtask

  task automatic test_hold();
    int lat; bit to;
    logic [255:0] snap;
    rand_rnd = 1'b1;
    drive_plain(64'hFEDCBA9876543210);
    run_vec(lat, to);
    n_checks++; if (to) $display("FAIL hold_timeout: got no out_valid expected out_valid"); else n_pass++;
    snap = {out_s0, out_s1, out_s2, out_s3};
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      drive_plain(rand64());
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid: cycle %0d got %b expected 1", i, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready: cycle %0d got %b expected 0", i, in_ready); else n_pass++;
      n_checks++;
      if ({out_s0, out_s1, out_s2, out_s3} !== snap) $display("FAIL hold_stable: cycle %0d shares changed", i);
      else n_pass++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_xor() !== 64'h1CE5046A98DF237B) $display("FAIL hold_result: got %h expected 1CE5046A98DF237B", out_xor());
    else n_pass++;
    finish_done();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k = 0, nacc = 0, acc0 = 0, acc1 = 0, lat = 0;
    bit drove_b = 1'b0;
    bit saw_first = 1'b0;
    rand_rnd  = 1'b1;
    out_ready = 1'b1;
    drive_plain(64'h0123456789ABCDEF);
    in_valid = 1'b1;
    while (nacc < 2 && k < 100) begin
      if (in_ready) begin
        if (nacc == 0) acc0 = k; else acc1 = k;
        nacc++;
      end
      if (out_valid && !saw_first) begin
        saw_first = 1'b1;
        n_checks++;
        if (out_xor() !== 64'hB732FD89A6405EC1) $display("FAIL b2b_first: got %h expected B732FD89A6405EC1", out_xor());
        else n_pass++;
      end
      tick();
      k++;
      if (nacc == 1 && !drove_b) begin
        drive_plain(64'hFEDCBA9876543210);
        drove_b = 1'b1;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (!saw_first) $display("FAIL b2b_first_seen: got no out_valid expected one"); else n_pass++;
    n_checks++; if (nacc != 2 || acc1 - acc0 != 18) $display("FAIL b2b_spacing: got %0d expected 18", acc1 - acc0); else n_pass++;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (out_xor() !== 64'h1CE5046A98DF237B || !out_valid)
      $display("FAIL b2b_second: got %h valid %b expected 1CE5046A98DF237B valid 1", out_xor(), out_valid);
    else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; bit saw = 1'b0;
    logic [63:0] p;
    rand_rnd = 1'b1;
    drive_plain(64'h0011223344556677);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (25) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    n_checks++; if (saw) $display("FAIL midrst_no_pulse: got out_valid 1 expected 0"); else n_pass++;
    p = 64'h89ABCDEF01234567;
    drive_plain(p);
    run_vec(lat, to);
    n_checks++; if (to || lat != 17) $display("FAIL midrst_latency: got %0d expected 17", lat); else n_pass++;
    n_checks++;
    if (out_xor() !== 64'hA6405EC1B732FD89) $display("FAIL midrst_result: got %h expected A6405EC1B732FD89", out_xor());
    else n_pass++;
    finish_done();
  endtask

  task automatic test_random();
    int lat; bit to;
    logic [63:0] p;
    rand_rnd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = rand64();
      drive_plain(p);
      run_vec(lat, to);
      n_checks++;
      if (to || out_xor() !== model(p))
        $display("FAIL random_%0d: in %h got %h expected %h", i, p, out_xor(), model(p));
      else n_pass++;
      finish_done();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vector();
    test_zero_input();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
